// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_MEM,
        HOLD,
        FAULT
    } fetch_state_t;

    // PC control word codes
    localparam logic [1:0] PC_HOLD  = 2'b00;
    localparam logic [1:0] PC_INC   = 2'b01;
    localparam logic [1:0] PC_LOAD  = 2'b10;
    localparam logic [1:0] PC_CLEAR = 2'b11;

endpackage

// File: rtl/fetch_timeout_timer.sv
// Memory-wait timer: counts enabled cycles and flags when TIMEOUT is reached.
// The count stops at TIMEOUT so it never wraps while the sequencer reacts.
module fetch_timeout_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

    logic [TW-1:0] count;

    // Count wait cycles; clear has priority, count holds at the limit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control sequencer: drives the PC control word, IR load
// strobe and memory request, handles branch redirects (including ones that
// arrive while a fetch is in flight) and flags memory timeouts.
// Optional build macro FETCH_PERF_EN adds fetch_count / stall_count outputs.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int N       = 16,
    parameter int TIMEOUT = 15
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         halt,
    input  logic         mem_ack,
    input  logic         instr_taken,
    input  logic         redirect,
    input  logic [N-1:0] redirect_addr,
    output logic [1:0]   pc_cw,
    output logic [N-1:0] pc_target,
    output logic         mem_req,
    output logic         ir_load,
    output logic         instr_valid,
    output logic         busy,
`ifdef FETCH_PERF_EN
    output logic [31:0]  fetch_count,
    output logic [31:0]  stall_count,
`endif
    output logic         fault
);

    fetch_state_t state, state_nxt;
    logic         halt_pend, halt_pend_nxt;
    logic         redir_pend, redir_pend_nxt;
    logic [N-1:0] redir_addr, redir_addr_nxt;
    logic         timer_clear, timer_en, timer_expired;
    logic         start_eff, start_accept, halt_seen;

    fetch_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    // Next-state decision and the cycle-immediate PC / IR controls
    always_comb begin
        state_nxt      = state;
        halt_pend_nxt  = halt_pend;
        redir_pend_nxt = redir_pend;
        redir_addr_nxt = redir_addr;
        pc_cw          = PC_HOLD;
        pc_target      = '0;
        ir_load        = 1'b0;
        timer_clear    = 1'b1;
        timer_en       = 1'b0;
        start_accept   = 1'b0;
        // keeps the PC clear strobe quiet while reset is held
        start_eff      = start & ~reset;
        halt_seen      = halt_pend | halt;

        case (state)
            IDLE: begin
                if (start_eff) begin
                    start_accept   = 1'b1;
                    pc_cw          = PC_CLEAR;
                    state_nxt      = REQ;
                    halt_pend_nxt  = 1'b0;
                    redir_pend_nxt = 1'b0;
                end
            end

            REQ, WAIT_MEM: begin
                if (halt) begin
                    halt_pend_nxt = 1'b1;
                end
                if (mem_ack) begin
                    if (redirect || redir_pend) begin
                        // data belongs to the abandoned path: drop it, refetch
                        pc_cw          = PC_LOAD;
                        pc_target      = redirect ? redirect_addr : redir_addr;
                        redir_pend_nxt = 1'b0;
                        state_nxt      = REQ;
                    end else begin
                        ir_load   = 1'b1;
                        state_nxt = HOLD;
                    end
                end else if ((state == WAIT_MEM) && timer_expired) begin
                    state_nxt      = FAULT;
                    halt_pend_nxt  = 1'b0;
                    redir_pend_nxt = 1'b0;
                end else begin
                    timer_clear = 1'b0;
                    timer_en    = 1'b1;
                    state_nxt   = WAIT_MEM;
                    if (redirect) begin
                        redir_pend_nxt = 1'b1;
                        redir_addr_nxt = redirect_addr;
                    end
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_cw         = PC_LOAD;
                    pc_target     = redirect_addr;
                    state_nxt     = halt_seen ? IDLE : REQ;
                    halt_pend_nxt = 1'b0;
                end else if (instr_taken) begin
                    pc_cw         = halt_seen ? PC_HOLD : PC_INC;
                    state_nxt     = halt_seen ? IDLE : REQ;
                    halt_pend_nxt = 1'b0;
                end else if (halt) begin
                    halt_pend_nxt = 1'b1;
                end
            end

            FAULT: begin
                if (start_eff) begin
                    start_accept   = 1'b1;
                    pc_cw          = PC_CLEAR;
                    state_nxt      = REQ;
                    halt_pend_nxt  = 1'b0;
                    redir_pend_nxt = 1'b0;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, pending flags and registered per-state outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            halt_pend   <= 1'b0;
            redir_pend  <= 1'b0;
            redir_addr  <= '0;
            mem_req     <= 1'b0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_nxt;
            halt_pend   <= halt_pend_nxt;
            redir_pend  <= redir_pend_nxt;
            redir_addr  <= redir_addr_nxt;
            mem_req     <= (state_nxt == REQ) || (state_nxt == WAIT_MEM);
            instr_valid <= (state_nxt == HOLD);
            busy        <= (state_nxt == REQ) || (state_nxt == WAIT_MEM) ||
                           (state_nxt == HOLD);
            fault       <= (state_nxt == FAULT);
        end
    end

`ifdef FETCH_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Performance counters: fetched instructions and memory stall cycles
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else if (start_accept) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (ir_load) begin
                fetch_count <= sat_inc(fetch_count);
            end
            if (state == WAIT_MEM) begin
                stall_count <= sat_inc(stall_count);
            end
        end
    end
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
`endif

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control FSM that sequences the instruction-fetch datapath: PC register, instruction register and instruction memory port.
- Drives a 2-bit PC control word plus the IR load strobe, and handshakes with memory and with the decode stage.
- Handles branch redirects, including redirects that arrive while a fetch is in flight, and flags memory timeouts.

Parameters:
- N, 16, PC/address width
- TIMEOUT, 15, max cycles in WAIT_MEM before fault (legal range 2..255)

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- start  input  1  begin fetching from address 0 (pulse)
- halt  input  1  stop after current instruction is consumed (pulse, captured sticky)
- mem_ack  input  1  instruction memory has data on bus this cycle
- instr_taken  input  1  decode consumed the instruction held in IR
- redirect  input  1  branch/jump taken, fetch from redirect_addr
- redirect_addr  input  N  redirect target
- pc_cw  output  2  PC control: 00 hold, 01 PC+4, 10 load pc_target, 11 clear to 0
- pc_target  output  N  value for PC load (valid when pc_cw==10)
- mem_req  output  1  fetch request to memory
- ir_load  output  1  IR captures memory data this cycle
- instr_valid  output  1  IR holds an unconsumed valid instruction
- busy  output  1  FSM not in IDLE or FAULT
- fault  output  1  sticky memory timeout flag

Behaviour:
- Reset: async, active-high. Clock: rising edge of clock. During/after reset: state IDLE; pc_cw=00, pc_target=0, mem_req=0, ir_load=0, instr_valid=0, busy=0, fault=0; halt_pend=0, redir_pend=0, timer=0.
- States: IDLE, REQ, WAIT_MEM, HOLD, FAULT. Outputs are Moore/Mealy as stated per state; pc_cw defaults to 00.
- IDLE:
  - start=1 -> pc_cw=11 this cycle, next REQ.
  - Otherwise stay in IDLE.
- REQ:
  - mem_req=1.
  - mem_ack=1 -> ir_load=1, next HOLD. Zero-wait fetch: 1 cycle from REQ entry to IR loaded.
  - mem_ack=0 -> timer=1, next WAIT_MEM.
- WAIT_MEM:
  - mem_req=1; timer increments each cycle.
  - mem_ack=1, redir_pend=0 -> ir_load=1, timer=0, next HOLD.
  - mem_ack=1, redir_pend=1 -> stale data discarded (ir_load=0), pc_cw=10 with pc_target=latched addr, clear redir_pend, next REQ.
  - No ack and timer==TIMEOUT -> next FAULT.
- HOLD:
  - instr_valid=1.
  - redirect=1 (priority over instr_taken): pc_cw=10, pc_target=redirect_addr, next REQ, or next IDLE if halt_pend.
  - Else instr_taken=1: pc_cw=01, next REQ, or IDLE (pc_cw=00) if halt_pend, then clear halt_pend.
  - Neither: hold, no timeout.
- Redirect in REQ or WAIT_MEM: set redir_pend, latch redirect_addr (newest wins). A redirect coincident with mem_ack in REQ is handled as the mem_ack + redir_pend case above.
- halt in any busy state: set halt_pend; takes effect only at HOLD exit. halt in IDLE is ignored.
- FAULT:
  - fault=1, mem_req=0.
  - start=1 -> clear fault, pc_cw=11, next REQ. Only reset or start leaves FAULT.
- start while busy: ignored.
- Mid-operation reset: all of the above reset values, immediately (async).

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds outputs fetch_count[31:0] (increments on each ir_load) and stall_count[31:0] (increments each cycle in WAIT_MEM).
  - Both reset to 0 and clear on start; saturating at all-ones.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Package fetch_pkg:
  - state enum fetch_state_t.
  - PC control codes PC_HOLD=00, PC_INC=01, PC_LOAD=10, PC_CLEAR=11.
- One sub-module: fetch_timeout_timer.
  - Inputs: clear, enable. Output: expired at TIMEOUT.
  - Width $clog2(TIMEOUT+1).

Test Plan:
- Reset then start, mem_ack tied 1, instr_taken tied 1 -> pc_cw sequence 11,01,01,... ir_load pulses 1 per 2 cycles; instr_valid alternates.
- WAIT_MEM of 3 cycles before ack -> mem_req high 4 cycles, single ir_load, timer back to 0, no fault.
- redirect=1, redirect_addr=16'h0040 in HOLD together with instr_taken -> pc_cw=10, pc_target=0x0040, next state REQ.
- redirect (0x0080) during WAIT_MEM, ack 2 cycles later -> no ir_load on that ack, pc_cw=10 with 0x0080, new REQ issued.
- mem_ack held 0 with TIMEOUT=15 -> fault=1 after 15 WAIT_MEM cycles, mem_req=0; later start -> fault=0, pc_cw=11.
- halt pulse during WAIT_MEM, then ack and instr_taken -> ends in IDLE with pc_cw=00, busy=0; async reset mid-WAIT_MEM -> all outputs 0 immediately.
